// File: rtl/jtframe_spi_dl.sv
// SPI download slave: oversamples the io controller SPI lines in the clk domain and turns
// file-transfer commands into the core-side ioctl write stream.
module jtframe_spi_dl #(
  parameter int unsigned     AW         = 22,
  parameter logic [AW-1:0]   ADDR_START = '0,
  parameter logic [7:0]      CMD_TX     = 8'h54,
  parameter logic [7:0]      CMD_DATA   = 8'h55,
  parameter logic [7:0]      CMD_INDEX  = 8'h53
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SPI_SCK,
  input  logic          SPI_SS2,
  input  logic          SPI_DI,
  output logic          downloading,
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_data,
  output logic          ioctl_wr,
  output logic [7:0]    ioctl_index
);

  typedef enum logic [2:0] {StIdle, StCtrl, StData, StIndex, StSkip} state_e;

  logic [1:0] sck_sync_q, ss_sync_q, di_sync_q;
  logic       sck_prev_q;
  logic       sck_s, ss_s, di_s, sck_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      ss_sync_q  <= '0;
      di_sync_q  <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], SPI_SCK};
      ss_sync_q  <= {ss_sync_q[0], SPI_SS2};
      di_sync_q  <= {di_sync_q[0], SPI_DI};
      sck_prev_q <= sck_s;
    end
  end

  assign sck_s    = sck_sync_q[1];
  assign ss_s     = ss_sync_q[1];
  assign di_s     = di_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // The eighth bit is taken straight from the line, so only seven bits need storing.
  logic [6:0] shift_q;
  logic [2:0] bitcnt_q;
  logic       byte_rdy_q;
  logic [7:0] byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bitcnt_q   <= '0;
      byte_rdy_q <= 1'b0;
      byte_q     <= '0;
    end else begin
      byte_rdy_q <= 1'b0;
      if (ss_s) begin
        bitcnt_q <= '0;
      end else if (sck_rise) begin
        shift_q  <= {shift_q[5:0], di_s};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          byte_rdy_q <= 1'b1;
          byte_q     <= {shift_q, di_s};
        end
      end
    end
  end

  state_e        state_q;
  logic          dl_q, wr_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q, index_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dl_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= ADDR_START;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      wr_q <= 1'b0;
      // Address advances the cycle after the strobe so the strobe sees the write address.
      if (wr_q) addr_q <= addr_q + AW'(1);
      if (ss_s) begin
        state_q <= StIdle;
      end else if (byte_rdy_q) begin
        unique case (state_q)
          StIdle: begin
            if      (byte_q == CMD_TX)    state_q <= StCtrl;
            else if (byte_q == CMD_DATA)  state_q <= StData;
            else if (byte_q == CMD_INDEX) state_q <= StIndex;
            else                          state_q <= StSkip;
          end
          StCtrl: begin
            if (byte_q == 8'hFF) begin
              dl_q   <= 1'b1;
              addr_q <= ADDR_START;
            end else if (byte_q == 8'h00) begin
              dl_q <= 1'b0;
            end
            state_q <= StSkip;
          end
          StIndex: begin
            index_q <= byte_q;
            state_q <= StSkip;
          end
          StData: begin
            if (dl_q) begin
              data_q <= byte_q;
              wr_q   <= 1'b1;
            end
          end
          StSkip: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign downloading = dl_q;
  assign ioctl_addr  = addr_q;
  assign ioctl_data  = data_q;
  assign ioctl_wr    = wr_q;
  assign ioctl_index = index_q;

endmodule

// File: tb/tb_jtframe_spi_dl.sv
// Bench for jtframe_spi_dl: two instances (start 0 and start near the top of the address
// space) share the SPI lines; a frame-level model predicts writes and output state.
module tb_jtframe_spi_dl;
  localparam int AW = 22;
  localparam logic [AW-1:0] START_W = 22'h3FFFFE;

  logic clk = 1'b0, rst_n = 1'b1, sck = 1'b0, ss2 = 1'b1, di = 1'b0;
  logic          dl   [2];
  logic [AW-1:0] addr [2];
  logic [7:0]    data [2];
  logic          wr   [2];
  logic [7:0]    idx  [2];

  jtframe_spi_dl #(.AW(AW), .ADDR_START(22'h0)) dut (
    .clk(clk), .rst_n(rst_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .downloading(dl[0]), .ioctl_addr(addr[0]), .ioctl_data(data[0]), .ioctl_wr(wr[0]),
    .ioctl_index(idx[0])
  );

  jtframe_spi_dl #(.AW(AW), .ADDR_START(START_W)) dut_w (
    .clk(clk), .rst_n(rst_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
    .downloading(dl[1]), .ioctl_addr(addr[1]), .ioctl_data(data[1]), .ioctl_wr(wr[1]),
    .ioctl_index(idx[1])
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor
  int unsigned last_rise = 0;
  logic [29:0] got_q0[$], got_q1[$], exp_q0[$], exp_q1[$];
  logic prev_wr0 = 1'b0, prev_wr1 = 1'b0;

  always @(negedge clk) begin
    if (wr[0]) begin
      check_eq("wr0_width", 32'(prev_wr0), 32'd0);
      check_eq("wr_latency", cyc - last_rise, 32'd4);
      got_q0.push_back({addr[0], data[0]});
    end
    if (wr[1]) begin
      check_eq("wr1_width", 32'(prev_wr1), 32'd0);
      got_q1.push_back({addr[1], data[1]});
    end
    prev_wr0 = wr[0];
    prev_wr1 = wr[1];
  end

  // Frame-level reference model
  logic          m_dl = 1'b0;
  logic [AW-1:0] m_addr [2];
  logic [7:0]    m_idx = 8'h00, m_data = 8'h00;
  logic [7:0]    fq[$];

  task automatic model_reset();
    m_dl = 1'b0; m_addr[0] = 22'h0; m_addr[1] = START_W; m_idx = 8'h00; m_data = 8'h00;
  endtask

  task automatic model_frame();
    if (fq.size() == 0) return;
    case (fq[0])
      8'h54: if (fq.size() > 1) begin
        if (fq[1] == 8'hFF) begin
          m_dl = 1'b1; m_addr[0] = 22'h0; m_addr[1] = START_W;
        end else if (fq[1] == 8'h00) m_dl = 1'b0;
      end
      8'h53: if (fq.size() > 1) m_idx = fq[1];
      8'h55: for (int i = 1; i < fq.size(); i++) begin
        if (m_dl) begin
          exp_q0.push_back({m_addr[0], fq[i]});
          exp_q1.push_back({m_addr[1], fq[i]});
          m_addr[0] = m_addr[0] + 1;
          m_addr[1] = m_addr[1] + 1;
          m_data = fq[i];
        end
      end
      default: ;
    endcase
  endtask

  // SPI driver (mode 0, MSB first, 3..6 clk per phase)
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      di = b[7-i];
      wait_clk($urandom_range(3, 6));
      sck = 1'b1;
      last_rise = cyc;
      wait_clk($urandom_range(3, 6));
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input int tail, input bit close);
    ss2 = 1'b0;
    wait_clk(3);
    foreach (fq[i]) send_bits(fq[i], 8);
    if (tail > 0) send_bits(8'($urandom), tail);
    wait_clk(3);
    if (close) begin
      ss2 = 1'b1;
      wait_clk($urandom_range(4, 8));
    end
  endtask

  task automatic do_frame(input int tail);
    send_frame(tail, 1'b1);
    model_frame();
  endtask

  task automatic verify_wr(input string tag);
    check_eq({tag, "_nwr0"}, got_q0.size(), exp_q0.size());
    check_eq({tag, "_nwr1"}, got_q1.size(), exp_q1.size());
    for (int i = 0; i < exp_q0.size() && i < got_q0.size(); i++)
      check_eq({tag, "_wr0"}, 32'(got_q0[i]), 32'(exp_q0[i]));
    for (int i = 0; i < exp_q1.size() && i < got_q1.size(); i++)
      check_eq({tag, "_wr1"}, 32'(got_q1[i]), 32'(exp_q1[i]));
    got_q0.delete(); got_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic verify_out(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, "_dl"},   32'(dl[k]),   32'(m_dl));
      check_eq({tag, "_addr"}, 32'(addr[k]), 32'(m_addr[k]));
      check_eq({tag, "_data"}, 32'(data[k]), 32'(m_data));
      check_eq({tag, "_idx"},  32'(idx[k]),  32'(m_idx));
      check_eq({tag, "_wr"},   32'(wr[k]),   32'd0);
    end
  endtask

  task automatic verify(input string tag);
    wait_clk(2);
    verify_wr(tag);
    verify_out(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, n, tail;
    logic [7:0] c;
    model_reset();
    #1 rst_n = 1'b0;
    #2 verify_out("reset");
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);

    fq = {8'h53, 8'h05}; do_frame(0);
    fq = {8'h54, 8'hFF}; do_frame(0);
    verify("start");

    fq = {8'h55, 8'hA5, 8'h3C, 8'h00, 8'hFF}; do_frame(0);
    verify("burst");

    fq = {8'h54, 8'h00}; do_frame(0);
    fq = {8'h55, 8'h11}; do_frame(0);
    verify("drop");

    fq = {8'h54, 8'hFF}; do_frame(0);
    fq = {8'h55}; do_frame(5);
    fq = {8'h55, 8'h77}; do_frame(0);
    verify("partial");

    fq = {8'h55, 8'h01, 8'h02, 8'h03}; do_frame(0);
    verify("wrap");

    for (int f = 0; f < 24; f++) begin
      r = $urandom_range(0, 9);
      fq.delete();
      case (r)
        0, 1: begin
          n = $urandom_range(0, 3);
          fq = {8'h54, (n < 2) ? 8'hFF : (n == 2) ? 8'h00 : 8'($urandom)};
          if ($urandom_range(0, 1) == 1) fq.push_back(8'($urandom));
        end
        2: fq = {8'h53, 8'($urandom)};
        8: begin
          c = 8'($urandom);
          if (c >= 8'h53 && c <= 8'h55) c = 8'h12;
          fq = {c, 8'hFF, 8'($urandom)};
        end
        9: ;
        default: begin
          fq = {8'h55};
          n = $urandom_range(0, 6);
          for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
        end
      endcase
      tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      do_frame(tail);
      verify("rnd");
    end

    // Asynchronous reset in the middle of a data byte
    fq = {8'h54, 8'hFF}; do_frame(0);
    fq = {8'h55, 8'hC1, 8'hC2};
    send_frame(4, 1'b0);
    model_frame();
    verify_wr("pre_rst");
    #2 rst_n = 1'b0;
    #1 model_reset();
    verify_out("async_rst");
    ss2 = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(4);
    fq = {8'h54, 8'hFF}; do_frame(0);
    fq = {8'h55, 8'h9A}; do_frame(0);
    verify("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
